// File: rtl/tl_pkg.sv
// Transaction-layer shared types: flow-control classes and helpers.
package tl_pkg;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } tl_fc_class_e;

  localparam int TL_NUM_FC_CLASS = 3;

  // One-hot (bit index = class) to class encoding; all-zero maps to FC_P.
  function automatic tl_fc_class_e onehot_to_class(input logic [TL_NUM_FC_CLASS-1:0] oh);
    tl_fc_class_e cls;
    cls = FC_P;
    if (oh[FC_NP])  cls = FC_NP;
    if (oh[FC_CPL]) cls = FC_CPL;
    return cls;
  endfunction

endpackage

// File: rtl/tl_arb_pick.sv
// Combinational credit eligibility and winner selection (fixed priority P > CPL > NP,
// with starved classes taking precedence over non-starved ones).
module tl_arb_pick
  import tl_pkg::*;
#(
  parameter int HDR_W = 12,
  parameter int DAT_W = 12
) (
  input  logic [TL_NUM_FC_CLASS-1:0]            req_i,
  input  logic [TL_NUM_FC_CLASS-1:0][DAT_W-1:0] dat_cr_i,
  input  logic [TL_NUM_FC_CLASS-1:0][HDR_W-1:0] avail_hdr_i,
  input  logic [TL_NUM_FC_CLASS-1:0][DAT_W-1:0] avail_dat_i,
  input  logic [TL_NUM_FC_CLASS-1:0]            starved_i,
  output logic [TL_NUM_FC_CLASS-1:0]            elig_o,
  output logic [TL_NUM_FC_CLASS-1:0]            win_o
);

  logic [TL_NUM_FC_CLASS-1:0] pool;

  always_comb begin
    elig_o = '0;
    for (int c = 0; c < TL_NUM_FC_CLASS; c++) begin
      elig_o[c] = req_i[c] && (avail_hdr_i[c] != '0) && (avail_dat_i[c] >= dat_cr_i[c]);
    end

    // Starved eligible classes, when present, are the only candidates.
    pool = (|(elig_o & starved_i)) ? (elig_o & starved_i) : elig_o;

    win_o = '0;
    if (pool[FC_P])        win_o[FC_P]   = 1'b1;
    else if (pool[FC_CPL]) win_o[FC_CPL] = 1'b1;
    else if (pool[FC_NP])  win_o[FC_NP]  = 1'b1;
  end

endmodule

// File: rtl/tl_tx_arb.sv
// Credit-aware TLP transmit arbiter: P/NP/CPL share one TX datapath, grant held per TLP.
// Optional starvation override is enabled by defining TL_TX_ARB_STARVE_EN.
module tl_tx_arb
  import tl_pkg::*;
#(
  parameter int HDR_W        = 12,
  parameter int DAT_W        = 12,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [TL_NUM_FC_CLASS-1:0]            req_i,
  input  logic [TL_NUM_FC_CLASS-1:0][DAT_W-1:0] dat_cr_i,
  input  logic [TL_NUM_FC_CLASS-1:0][HDR_W-1:0] avail_hdr_i,
  input  logic [TL_NUM_FC_CLASS-1:0][DAT_W-1:0] avail_dat_i,
  input  logic                                  tlp_last_i,
  output logic [TL_NUM_FC_CLASS-1:0]            gnt_o,
  output logic                                  cons_valid_o,
  output logic [1:0]                            cons_class_o,
  output logic [DAT_W-1:0]                      cons_dat_o,
  output logic                                  busy_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Handshake: a grant is raised one cycle after an IDLE decision and held until the link
  // reports tlp_last_i; cons_valid_o pulses only on the first ACTIVE cycle.
  state_e                                state;
  logic [TL_NUM_FC_CLASS-1:0]            elig;
  logic [TL_NUM_FC_CLASS-1:0]            win;
  logic [TL_NUM_FC_CLASS-1:0]            starved;
  logic [TL_NUM_FC_CLASS-1:0][CNT_W-1:0] starve_cnt;
  tl_fc_class_e                          win_cls;

  always_comb begin
    starved = '0;
    for (int c = 0; c < TL_NUM_FC_CLASS; c++) begin
      starved[c] = (starve_cnt[c] == CNT_W'(STARVE_LIMIT));
    end
    win_cls = onehot_to_class(win);
  end

  tl_arb_pick #(
    .HDR_W (HDR_W),
    .DAT_W (DAT_W)
  ) u_pick (
    .req_i       (req_i),
    .dat_cr_i    (dat_cr_i),
    .avail_hdr_i (avail_hdr_i),
    .avail_dat_i (avail_dat_i),
    .starved_i   (starved),
    .elig_o      (elig),
    .win_o       (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      gnt_o        <= '0;
      cons_valid_o <= 1'b0;
      cons_class_o <= 2'd0;
      cons_dat_o   <= '0;
      busy_o       <= 1'b0;
    end else begin
      cons_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|win) begin
            state        <= ST_ACTIVE;
            gnt_o        <= win;
            busy_o       <= 1'b1;
            cons_valid_o <= 1'b1;
            cons_class_o <= win_cls;
            cons_dat_o   <= dat_cr_i[win_cls];
          end
        end
        ST_ACTIVE: begin
          if (tlp_last_i) begin
            state  <= ST_IDLE;
            gnt_o  <= '0;
            busy_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TL_TX_ARB_STARVE_EN
  // Counters only move on IDLE decision cycles; a win clears, an eligible loss saturates up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      for (int c = 0; c < TL_NUM_FC_CLASS; c++) begin
        if (win[c]) begin
          starve_cnt[c] <= '0;
        end else if (elig[c] && !starved[c]) begin
          starve_cnt[c] <= starve_cnt[c] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_tl_tx_arb.sv
// Directed bench for tl_tx_arb: table of single-decision vectors plus multi-cycle sequences.
module tb_tl_tx_arb;

  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [2:0]          req_i = '0;
  logic [2:0][W-1:0]   dat_cr_i = '0;
  logic [2:0][W-1:0]   avail_hdr_i = '0;
  logic [2:0][W-1:0]   avail_dat_i = '0;
  logic                tlp_last_i = 1'b0;
  logic [2:0]          gnt_o;
  logic                cons_valid_o;
  logic [1:0]          cons_class_o;
  logic [W-1:0]        cons_dat_o;
  logic                busy_o;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  tl_tx_arb #(.HDR_W(W), .DAT_W(W), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .dat_cr_i     (dat_cr_i),
    .avail_hdr_i  (avail_hdr_i),
    .avail_dat_i  (avail_dat_i),
    .tlp_last_i   (tlp_last_i),
    .gnt_o        (gnt_o),
    .cons_valid_o (cons_valid_o),
    .cons_class_o (cons_class_o),
    .cons_dat_o   (cons_dat_o),
    .busy_o       (busy_o)
  );

  // clock/reset
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        req;
    logic [2:0][W-1:0] cr;
    logic [2:0][W-1:0] hdr;
    logic [2:0][W-1:0] dat;
    logic [2:0]        exp_gnt;
    logic [1:0]        exp_cls;
    logic [W-1:0]      exp_dat;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [2:0] req,
                              input int c0, input int c1, input int c2,
                              input int h0, input int h1, input int h2,
                              input int a0, input int a1, input int a2,
                              input logic [2:0] eg, input logic [1:0] ecls, input int edat);
    vec_t v;
    v.req = req;
    v.cr  = {W'(c2), W'(c1), W'(c0)};
    v.hdr = {W'(h2), W'(h1), W'(h0)};
    v.dat = {W'(a2), W'(a1), W'(a0)};
    v.exp_gnt = eg;
    v.exp_cls = ecls;
    v.exp_dat = W'(edat);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ample_credits();
    dat_cr_i    = {W'(4), W'(4), W'(4)};
    avail_hdr_i = {W'(8), W'(8), W'(8)};
    avail_dat_i = {W'(64), W'(64), W'(64)};
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    req_i = '0;
    tlp_last_i = 1'b0;
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic check_idle(input string name);
    check({name, "_gnt"}, 32'(gnt_o), 32'd0);
    check({name, "_cons"}, 32'(cons_valid_o), 32'd0);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    // reset state while rst_n is low
    #3;
    check_idle("reset");
    check("reset_cls", 32'(cons_class_o), 32'd0);
    check("reset_dat", 32'(cons_dat_o), 32'd0);
    #9 rst_n = 1'b1;
    step();

    //                req     cr p,np,cpl      hdr p,np,cpl  avail p,np,cpl     gnt    cls  dat
    vecs[0] = mk(3'b010,    0,    8,  0,      0, 4, 0,     0,   16,  0,    3'b010, 2'd1, 8);
    vecs[1] = mk(3'b001,    0,    0,  0,      1, 0, 0,     0,    0,  0,    3'b001, 2'd0, 0);
    vecs[2] = mk(3'b100,    0,    0, 10,      0, 0, 4,     0,    0,  9,    3'b000, 2'd0, 0);
    vecs[3] = mk(3'b100,    0,    0, 10,      0, 0, 4,     0,    0, 10,    3'b100, 2'd2, 10);
    vecs[4] = mk(3'b111,    3,    5,  7,      2, 2, 2,    32,   32, 32,    3'b001, 2'd0, 3);
    vecs[5] = mk(3'b110,    3,    5,  7,      2, 2, 2,    32,   32, 32,    3'b100, 2'd2, 7);
    vecs[6] = mk(3'b011,    3,    5,  7,      0, 2, 2,    32,   32, 32,    3'b010, 2'd1, 5);
    vecs[7] = mk(3'b111,   40,    5,  6,      2, 2, 2,    39,   32, 32,    3'b100, 2'd2, 6);
    vecs[8] = mk(3'b111,    0,    0,  0,      0, 0, 0,    32,   32, 32,    3'b000, 2'd0, 0);
    vecs[9] = mk(3'b001, 4095,    0,  0,   4095, 0, 0,  4095,    0,  0,    3'b001, 2'd0, 4095);

    for (int i = 0; i < 10; i++) begin
      req_i = vecs[i].req;
      dat_cr_i = vecs[i].cr;
      avail_hdr_i = vecs[i].hdr;
      avail_dat_i = vecs[i].dat;
      step();
      check($sformatf("v%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].exp_gnt));
      check($sformatf("v%0d_cons", i), 32'(cons_valid_o), 32'(vecs[i].exp_gnt != 3'b000));
      check($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].exp_gnt != 3'b000));
      if (vecs[i].exp_gnt != 3'b000) begin
        check($sformatf("v%0d_cls", i), 32'(cons_class_o), 32'(vecs[i].exp_cls));
        check($sformatf("v%0d_dat", i), 32'(cons_dat_o), 32'(vecs[i].exp_dat));
        // held grant ignores dropped request and vanished credits
        req_i = '0;
        avail_hdr_i = '0;
        avail_dat_i = '0;
        step();
        check($sformatf("v%0d_hold", i), 32'(gnt_o), 32'(vecs[i].exp_gnt));
        check($sformatf("v%0d_pulse_end", i), 32'(cons_valid_o), 32'd0);
        tlp_last_i = 1'b1;
        step();
        tlp_last_i = 1'b0;
        check_idle($sformatf("v%0d_end", i));
      end else begin
        req_i = '0;
        step();
      end
    end

    // P and NP together: P first, one idle cycle, then NP
    ample_credits();
    req_i = 3'b011;
    step();
    check("pnp_first", 32'(gnt_o), 32'b001);
    req_i = 3'b010;
    tlp_last_i = 1'b1;
    step();
    tlp_last_i = 1'b0;
    check_idle("pnp_gap");
    step();
    check("pnp_second", 32'(gnt_o), 32'b010);
    check("pnp_second_cls", 32'(cons_class_o), 32'd1);
    req_i = '0;
    tlp_last_i = 1'b1;
    step();
    tlp_last_i = 1'b0;

    // CPL short by one data credit waits, then grants the cycle after credit arrives
    dat_cr_i[2] = W'(10);
    avail_dat_i[2] = W'(9);
    req_i = 3'b100;
    step();
    step();
    check_idle("cpl_wait");
    avail_dat_i[2] = W'(10);
    step();
    check("cpl_go", 32'(gnt_o), 32'b100);
    check("cpl_go_dat", 32'(cons_dat_o), 32'd10);
    req_i = '0;
    tlp_last_i = 1'b1;
    step();
    tlp_last_i = 1'b0;

    // tlp_last in IDLE is ignored; decision still proceeds
    tlp_last_i = 1'b1;
    step();
    check_idle("last_idle");
    req_i = 3'b001;
    step();
    tlp_last_i = 1'b0;
    check("last_idle_gnt", 32'(gnt_o), 32'b001);
    req_i = '0;
    tlp_last_i = 1'b1;
    step();
    tlp_last_i = 1'b0;

    // async reset mid-grant
    ample_credits();
    req_i = 3'b001;
    step();
    check("rst_pre", 32'(gnt_o), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    #3 rst_n = 1'b1;
    step();
    check("rst_rearb", 32'(gnt_o), 32'b001);
    check("rst_rearb_cons", 32'(cons_valid_o), 32'd1);
    req_i = '0;
    tlp_last_i = 1'b1;
    step();
    tlp_last_i = 1'b0;

    // single-beat TLP: exactly one consume pulse
    req_i = 3'b010;
    step();
    check("one_gnt", 32'(gnt_o), 32'b010);
    check("one_cons", 32'(cons_valid_o), 32'd1);
    req_i = '0;
    tlp_last_i = 1'b1;
    step();
    tlp_last_i = 1'b0;
    check_idle("one_exit");
    step();
    check_idle("one_after");

    // continuous P + NP traffic, scoreboarded grant sequence
    do_reset();
    ample_credits();
`ifdef TL_TX_ARB_STARVE_EN
    for (int i = 1; i <= 18; i++) exp_q.push_back((i == 9 || i == 18) ? 3'b010 : 3'b001);
`else
    for (int i = 1; i <= 12; i++) exp_q.push_back(3'b001);
`endif
    req_i = 3'b011;
    for (int n = 0; exp_q.size() > 0; n++) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      step();
      check($sformatf("starve_d%0d", n + 1), 32'(gnt_o), 32'(e));
      tlp_last_i = 1'b1;
      step();
      tlp_last_i = 1'b0;
    end
    req_i = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
